// File: rtl/extensor_de_sinal.sv
// Sign/zero extender for the datapath immediate field.
// Combinational result for same-cycle consumers, plus a registered copy with a
// one-cycle valid flag for pipelined consumers.
//
// Ports:
//   Clock        in   rising-edge clock for the registered outputs
//   Reset        in   asynchronous active-high reset of the registered outputs
//   Entrada      in   IN_WIDTH value to extend (two's complement when ZeroExt=0)
//   ZeroExt      in   0 = sign extend, 1 = zero extend
//   Habilita     in   load enable for the output register
//   Resultado    out  OUT_WIDTH combinational extended value
//   Negativo     out  combinational, Entrada MSB in sign mode, 0 in zero mode
//   ResultadoReg out  OUT_WIDTH registered extended value
//   Valido       out  high for one cycle after each Habilita cycle
module extensor_de_sinal #(
    parameter int unsigned IN_WIDTH  = 5,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [IN_WIDTH-1:0]  Entrada,
    input  logic                 ZeroExt,
    input  logic                 Habilita,
    output logic [OUT_WIDTH-1:0] Resultado,
    output logic                 Negativo,
    output logic [OUT_WIDTH-1:0] ResultadoReg,
    output logic                 Valido
);

    logic [OUT_WIDTH-1:0] ext_c;
    logic [OUT_WIDTH-1:0] resultado_d;
    logic [OUT_WIDTH-1:0] resultado_q;
    logic                 valido_d;
    logic                 valido_q;

    // Extension network; equal widths need their own branch since a
    // zero-width replication is illegal.
    if (IN_WIDTH < 1) begin : g_bad_in
        $error("extensor_de_sinal: IN_WIDTH must be >= 1");
    end else if (OUT_WIDTH < IN_WIDTH) begin : g_bad_out
        $error("extensor_de_sinal: OUT_WIDTH must be >= IN_WIDTH");
    end else if (OUT_WIDTH == IN_WIDTH) begin : g_same
        assign ext_c = Entrada;
    end else begin : g_ext
        localparam int unsigned EXT_W = OUT_WIDTH - IN_WIDTH;
        // Fill bit is the MSB in sign mode, forced to 0 in zero mode.
        assign ext_c = {{EXT_W{Entrada[IN_WIDTH-1] & ~ZeroExt}}, Entrada};
    end

    assign Resultado = ext_c;
    assign Negativo  = Entrada[IN_WIDTH-1] & ~ZeroExt;

    // Next state: load on Habilita, otherwise hold; valid tracks Habilita.
    always_comb begin
        resultado_d = resultado_q;
        valido_d    = 1'b0;
        if (Habilita) begin
            resultado_d = ext_c;
            valido_d    = 1'b1;
        end
    end

    // Output register; Reset clears immediately and wins over the clock.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            resultado_q <= '0;
            valido_q    <= 1'b0;
        end else begin
            resultado_q <= resultado_d;
            valido_q    <= valido_d;
        end
    end

    assign ResultadoReg = resultado_q;
    assign Valido       = valido_q;

endmodule

// File: tb/tb_extensor_de_sinal.sv
module tb_extensor_de_sinal;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [4:0] Entrada;
    logic       ZeroExt;
    logic       Habilita;
    logic [7:0] Resultado;
    logic       Negativo;
    logic [7:0] ResultadoReg;
    logic       Valido;

    // Equal-width instance
    logic       Reset8;
    logic [7:0] Entrada8;
    logic       ZeroExt8;
    logic       Habilita8;
    logic [7:0] Resultado8;
    logic       Negativo8;
    logic [7:0] ResultadoReg8;
    logic       Valido8;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t       sb_q[$];
    logic [7:0] mdl_reg;
    logic       mdl_val;

    always #5 Clock = ~Clock;

    extensor_de_sinal dut (
        .Clock(Clock), .Reset(Reset), .Entrada(Entrada), .ZeroExt(ZeroExt),
        .Habilita(Habilita), .Resultado(Resultado), .Negativo(Negativo),
        .ResultadoReg(ResultadoReg), .Valido(Valido)
    );

    extensor_de_sinal #(.IN_WIDTH(8), .OUT_WIDTH(8)) dut8 (
        .Clock(Clock), .Reset(Reset8), .Entrada(Entrada8), .ZeroExt(ZeroExt8),
        .Habilita(Habilita8), .Resultado(Resultado8), .Negativo(Negativo8),
        .ResultadoReg(ResultadoReg8), .Valido(Valido8)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference extension: value-preserving widening of a 5-bit field.
    function automatic logic [7:0] ext5(input logic [4:0] e, input logic z);
        logic signed [7:0] s;
        s = 8'($signed(e));
        return z ? {3'b000, e} : s;
    endfunction

    // One stimulus cycle: drive at negedge, push the expected post-edge state.
    task automatic drive_cycle(input logic rst, input logic [4:0] e, input logic z, input logic h);
        exp_t x;
        @(negedge Clock);
        Reset    = rst;
        Entrada  = e;
        ZeroExt  = z;
        Habilita = h;
        if (rst) begin
            mdl_reg = 8'h00;
            mdl_val = 1'b0;
        end else begin
            if (h) mdl_reg = ext5(e, z);
            mdl_val = h;
        end
        x.data  = mdl_reg;
        x.valid = mdl_val;
        sb_q.push_back(x);
        #1;
        check_eq("comb_res", Resultado, ext5(e, z));
        @(posedge Clock);
        #2;
    endtask

    // Monitor: compare registered outputs against the scoreboard after each edge.
    always @(posedge Clock) begin
        exp_t x;
        #1;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check_eq("reg_data", ResultadoReg, x.data);
            check_eq("reg_valid", Valido, x.valid);
        end
    end

    initial begin
        Reset = 1'b1; Entrada = 5'd0; ZeroExt = 1'b0; Habilita = 1'b0;
        Reset8 = 1'b1; Entrada8 = 8'h00; ZeroExt8 = 1'b0; Habilita8 = 1'b0;
        mdl_reg = 8'h00; mdl_val = 1'b0;
        #2;
        check_eq("rst_data", ResultadoReg, 8'h00);
        check_eq("rst_valid", Valido, 1'b0);

        // Combinational sweep, both modes
        for (int zi = 0; zi < 2; zi++) begin
            for (int i = 0; i < 32; i++) begin
                Entrada = 5'(i);
                ZeroExt = 1'(zi);
                #1;
                check_eq("sweep_res", Resultado, ext5(5'(i), 1'(zi)));
                check_eq("sweep_neg", Negativo, (zi == 0) ? 32'((i >> 4) & 1) : 32'd0);
            end
        end
        Entrada = 5'b10000; ZeroExt = 1'b0; #1;
        check_eq("sign_10000", Resultado, 8'hF0);
        ZeroExt = 1'b1; #1;
        check_eq("zero_10000", Resultado, 8'h10);
        check_eq("zero_neg", Negativo, 1'b0);
        Entrada = 5'b11111; #1;
        check_eq("zero_11111", Resultado, 8'h1F);

        // Load attempt during reset, then first edge after release
        drive_cycle(1'b1, 5'b10101, 1'b0, 1'b1);
        drive_cycle(1'b0, 5'b10101, 1'b0, 1'b1);
        // One-cycle pulse then hold
        drive_cycle(1'b0, 5'b00110, 1'b0, 1'b1);
        drive_cycle(1'b0, 5'b11000, 1'b0, 1'b0);
        check_eq("hold_comb", Resultado, 8'hF8);
        // Back-to-back loads
        drive_cycle(1'b0, 5'b11111, 1'b1, 1'b1);
        drive_cycle(1'b0, 5'b11111, 1'b0, 1'b1);
        check_eq("pre_async", ResultadoReg, 8'hFF);

        // Asynchronous reset between edges
        @(negedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        check_eq("async_data", ResultadoReg, 8'h00);
        check_eq("async_valid", Valido, 1'b0);
        mdl_reg = 8'h00;
        mdl_val = 1'b0;
        drive_cycle(1'b1, 5'b01010, 1'b0, 1'b1);
        drive_cycle(1'b0, 5'b01010, 1'b0, 1'b1);

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            drive_cycle(1'b0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
        end

        // Equal-width instance: pass-through in both modes
        Entrada8 = 8'h80; ZeroExt8 = 1'b0; #1;
        check_eq("w8_sign", Resultado8, 8'h80);
        check_eq("w8_sign_neg", Negativo8, 1'b1);
        ZeroExt8 = 1'b1; #1;
        check_eq("w8_zero", Resultado8, 8'h80);
        check_eq("w8_zero_neg", Negativo8, 1'b0);

        @(posedge Clock);
        #3;
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/extensor_de_sinal.md
Name: extensor_de_sinal

Overview:
- Parameterised sign extender for the 8-bit processor datapath; widens the 5-bit immediate field to the 8-bit data width.
- Provides a combinational result for same-cycle use by the ALU/operand mux.
- Also provides a registered copy with a valid flag for pipelined consumers.
- A mode input selects sign extension (default) or zero extension.

Parameters:
- IN_WIDTH, 5, width of Entrada; must be >= 1.
- OUT_WIDTH, 8, width of Resultado/ResultadoReg; must be >= IN_WIDTH (elaboration error otherwise).

Ports:
- Clock  input  1  rising-edge clock for registered outputs.
- Reset  input  1  asynchronous, active-high reset.
- Entrada  input  IN_WIDTH  value to extend, two's complement when ZeroExt=0.
- ZeroExt  input  1  0 = sign extend, 1 = zero extend.
- Habilita  input  1  load enable for the output register.
- Resultado  output  OUT_WIDTH  combinational extended value.
- Negativo  output  1  combinational; = Entrada[IN_WIDTH-1] & ~ZeroExt.
- ResultadoReg  output  OUT_WIDTH  registered extended value.
- Valido  output  1  registered; high for one cycle after each Habilita cycle.

Behaviour:
Combinational path (no clock, zero latency):
- Resultado[IN_WIDTH-1:0] = Entrada.
- Resultado[OUT_WIDTH-1:IN_WIDTH] = all copies of Entrada[IN_WIDTH-1] when ZeroExt=0, all zeros when ZeroExt=1.
- If OUT_WIDTH == IN_WIDTH, Resultado = Entrada in both modes.
- With defaults, Resultado = {3{Entrada[4]}, Entrada} (sign mode).
- Arithmetic value is preserved: signed(Resultado) == signed(Entrada) in sign mode; unsigned equality holds in zero mode.
- Resultado and Negativo follow any change on Entrada or ZeroExt with no registered delay; no latches.
- X on Entrada propagates as X; no X-suppression logic.

Registered path:
- Reset high, asynchronously: ResultadoReg = 0 and Valido = 0, held while Reset is asserted.
- On rising Clock with Reset low and Habilita = 1: ResultadoReg <= Resultado and Valido <= 1.
- On rising Clock with Reset low and Habilita = 0: ResultadoReg holds its value and Valido <= 0.
- Latency: one cycle from Entrada/ZeroExt sampled with Habilita to ResultadoReg.
- Back-to-back Habilita cycles each load a new value; Valido stays high continuously.
- Reset asserted mid-operation clears both registers immediately, without waiting for a clock edge.
- The first edge after Reset deasserts behaves as a normal edge.
- Reset and rising Clock together: Reset wins.

Test Plan:
- Sweep Entrada 0..31, one step per time unit, ZeroExt=0 -> Resultado = {3{Entrada[4]},Entrada} for every value: 0->00000000, 5'b01111->00001111, 5'b10000->11110000, 5'b11111->11111111; Negativo = Entrada[4].
- ZeroExt=1 with Entrada=5'b10000 -> Resultado=00010000, Negativo=0; with Entrada=5'b11111 -> 00011111.
- Reset=1, then Habilita=1 with Entrada=5'b10101 and one clock edge -> ResultadoReg=00000000 and Valido=0 while Reset is high. Release Reset, one edge -> ResultadoReg=11110101, Valido=1.
- Habilita pulse for one cycle with Entrada=5'b00110, then Habilita=0 with Entrada changed to 5'b11000 -> ResultadoReg stays 00000110 and Valido drops to 0 on the next edge; Resultado shows 11111000 immediately.
- Assert Reset between clock edges while ResultadoReg=11111111 -> ResultadoReg=0 and Valido=0 immediately, before the next edge.
- Re-elaborate with IN_WIDTH=8, OUT_WIDTH=8 -> Resultado = Entrada for 8'h80 in both modes.
